mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the instruction-fetch requester (IF) and the
//  load/store requester (MEM stage). One transaction is outstanding at a time. Data wins by
//  default; a streak counter guarantees fetch progress. Raises stall_o so the control logic
//  freezes the instruction registers while the pipeline waits for memory.
// PARAMETERS
//  AW          32  address width (bits)
//  DW          32  data width (bits)
//  MAX_DSTREAK 4   max consecutive data grants while IF pending before IF is forced (>=1)
//  TIMEOUT     64  cycles in a WAIT state without mem_rvalid_i before abort (>=2)
// PORTS
//  clk          in   1    main clock, rising edge
//  rst_n        in   1    asynchronous active-low reset
//  if_req_i     in   1    fetch request, held until if_gnt_o
//  if_addr_i    in   AW   fetch address
//  if_gnt_o     out  1    fetch accepted this cycle
//  if_rvalid_o  out  1    fetch data valid (1-cycle pulse)
//  if_rdata_o   out  DW   fetch data
//  d_req_i      in   1    data request, held until d_gnt_o
//  d_we_i       in   1    1 = store, 0 = load
//  d_size_i     in   2    00 byte, 01 half, 10 word (passed through)
//  d_addr_i     in   AW   data address
//  d_wdata_i    in   DW   store data
//  d_gnt_o      out  1    data accepted this cycle
//  d_rvalid_o   out  1    load data valid / store complete (1-cycle pulse)
//  d_rdata_o    out  DW   load data
//  mem_req_o    out  1    memory request
//  mem_we_o     out  1    memory write enable
//  mem_size_o   out  2    memory access size
//  mem_addr_o   out  AW   memory address
//  mem_wdata_o  out  DW   memory write data
//  mem_gnt_i    in   1    memory accepts request this cycle
//  mem_rvalid_i in   1    memory response valid
//  mem_rdata_i  in   DW   memory response data
//  stall_o      out  1    pipeline stall
//  err_o        out  1    sticky timeout flag, cleared only by reset
// BEHAVIOUR
//  States: IDLE, WAIT_I, WAIT_D. Reset (async, rst_n=0): state=IDLE, streak=0, timer=0,
//   all outputs 0. Deassertion takes effect at the next rising edge.
//  IDLE arbitration (combinational, same cycle):
//   - d_req_i && !(if_req_i && streak==MAX_DSTREAK) -> select D; else if_req_i -> select I.
//   - mem_req_o=1 and mem_* driven from the selected requester. IF side drives mem_we_o=0,
//     mem_size_o=10, mem_wdata_o=0.
//   - gnt to the selected requester = mem_gnt_i. Registered on grant: state -> WAIT_D/WAIT_I.
//  streak: +1 on each D grant while if_req_i=1 (saturates at MAX_DSTREAK); 0 on any I grant.
//  WAIT_x: mem_req_o=0; no grants. On mem_rvalid_i: x_rvalid_o=1 and x_rdata_o=mem_rdata_i
//   in the same cycle; state -> IDLE. New grant earliest next cycle (accept-to-accept >= 2).
//  timer: counts WAIT cycles. Reaching TIMEOUT-1 without mem_rvalid_i -> err_o=1,
//   x_rvalid_o pulses with rdata=0, state -> IDLE. Reset to 0 on every state change.
//  rdata outputs are 0 whenever the matching rvalid is 0.
//  stall_o = (if_req_i && !if_gnt_o) || (d_req_i && !d_gnt_o) || (state==WAIT_D).
//   A WAIT_I alone does not stall: IF handles its own bubble.
//  mem_rvalid_i in IDLE is ignored. A requester dropping req before grant is legal; no grant.
//  Both reqs with mem_gnt_i=0: the selection is held (no switching) until granted.
//  Reset mid-transaction: abort immediately; the late mem_rvalid_i is ignored (state IDLE).
// TESTING
//  Lone IF req addr 0x100, mem_gnt_i=1, rvalid 2 cycles later data 0xDEADBEEF ->
//   if_gnt_o 1 cycle, if_rvalid_o pulse with 0xDEADBEEF, stall_o=0 in WAIT_I.
//  IF and D req the same cycle (store 0x20 <- 0x55, size 00) -> D granted first: mem_we_o=1,
//   mem_size_o=00. IF granted in the cycle after d_rvalid_o.
//  IF pending, D requesting every cycle, MAX_DSTREAK=4 -> exactly 4 D grants, then an IF grant,
//   then streak=0.
//  mem_gnt_i=0 for 3 cycles with d_req_i -> mem_req_o held, addr stable, stall_o=1, no gnt.
//  D granted, no mem_rvalid_i for TIMEOUT=64 cycles -> err_o=1 sticky, d_rvalid_o pulse with
//   rdata=0, state IDLE.
//  rst_n low during WAIT_D, then a stray mem_rvalid_i -> all outputs 0, no rvalid pulse.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, load/store and unified-memory handshake signals of the memory port arbiter.
// Signal directions carry the arbiter's point of view; "slave" is the arbiter, "master" its environment.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [DW-1:0] if_rdata_o;

    logic          d_req_i;
    logic          d_we_i;
    logic [1:0]    d_size_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i;
    logic          d_gnt_o;
    logic          d_rvalid_o;
    logic [DW-1:0] d_rdata_o;

    logic          mem_req_o;
    logic          mem_we_o;
    logic [1:0]    mem_size_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i;
    logic          mem_rvalid_i;
    logic [DW-1:0] mem_rdata_i;

    logic          stall_o;
    logic          err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output stall_o, err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_size_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  stall_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction in flight,
// data-first with a streak limit that guarantees fetch progress, plus a response timeout.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    state_t        r_state;
    logic [SW-1:0] r_streak;
    logic [TW-1:0] r_timer;
    logic          r_err;
    logic          r_hold;
    logic          r_hold_d;

    logic          w_idle;
    logic          w_hold_ok;
    logic          w_sel_d;
    logic          w_sel_i;
    logic          w_d_gnt;
    logic          w_i_gnt;
    logic          w_done;
    logic          w_d_rvalid;
    logic          w_i_rvalid;
    logic [DW-1:0] w_rdata;
    logic [AW-1:0] w_mem_addr;

    // An ungranted selection stays locked while its requester keeps asking, so the bus never switches mid-request.
    always_comb begin
        w_idle     = (r_state == IDLE) && rst_n;
        w_hold_ok  = r_hold && (r_hold_d ? bus.d_req_i : bus.if_req_i);
        w_sel_d    = w_hold_ok ? r_hold_d
                               : (bus.d_req_i && !(bus.if_req_i && (r_streak == SMAX)));
        w_sel_i    = !w_sel_d && bus.if_req_i;
        w_d_gnt    = w_idle && w_sel_d && bus.mem_gnt_i;
        w_i_gnt    = w_idle && w_sel_i && bus.mem_gnt_i;
        w_done     = bus.mem_rvalid_i || (r_timer == TMAX);
        w_d_rvalid = (r_state == WAIT_D) && w_done;
        w_i_rvalid = (r_state == WAIT_I) && w_done;
        w_rdata    = bus.mem_rvalid_i ? bus.mem_rdata_i : {DW{1'b0}};
        w_mem_addr = {AW{1'b0}};
        if (w_idle && w_sel_d)
            w_mem_addr = bus.d_addr_i;
        else if (w_idle && w_sel_i)
            w_mem_addr = bus.if_addr_i;
    end

    assign bus.mem_req_o   = w_idle && (w_sel_d || w_sel_i);
    assign bus.mem_we_o    = w_idle && w_sel_d && bus.d_we_i;
    assign bus.mem_size_o  = !w_idle ? 2'b00 : (w_sel_d ? bus.d_size_i : (w_sel_i ? 2'b10 : 2'b00));
    assign bus.mem_addr_o  = w_mem_addr;
    assign bus.mem_wdata_o = (w_idle && w_sel_d) ? bus.d_wdata_i : {DW{1'b0}};

    assign bus.if_gnt_o    = w_i_gnt;
    assign bus.d_gnt_o     = w_d_gnt;
    assign bus.if_rvalid_o = w_i_rvalid;
    assign bus.d_rvalid_o  = w_d_rvalid;
    assign bus.if_rdata_o  = w_i_rvalid ? w_rdata : {DW{1'b0}};
    assign bus.d_rdata_o   = w_d_rvalid ? w_rdata : {DW{1'b0}};
    assign bus.err_o       = r_err;

    // A fetch waiting on its own response is not a stall; the fetch unit bubbles by itself.
    assign bus.stall_o = rst_n && ((bus.if_req_i && !w_i_gnt) ||
                                   (bus.d_req_i && !w_d_gnt) ||
                                   (r_state == WAIT_D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_streak <= '0;
            r_timer  <= '0;
            r_err    <= 1'b0;
            r_hold   <= 1'b0;
            r_hold_d <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_timer <= '0;
                    if (w_d_gnt) begin
                        r_state <= WAIT_D;
                        r_hold  <= 1'b0;
                        if (bus.if_req_i && (r_streak != SMAX))
                            r_streak <= r_streak + 1'b1;
                    end else if (w_i_gnt) begin
                        r_state  <= WAIT_I;
                        r_hold   <= 1'b0;
                        r_streak <= '0;
                    end else if (w_sel_d || w_sel_i) begin
                        r_hold   <= 1'b1;
                        r_hold_d <= w_sel_d;
                    end else begin
                        r_hold <= 1'b0;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (bus.mem_rvalid_i) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                    end else if (r_timer == TMAX) begin
                        r_state <= IDLE;
                        r_timer <= '0;
                        r_err   <= 1'b1;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_timer <= '0;
                end
            endcase
        end
    end
endmodule
